alu_sweep_sequencer: RTL and testbench
======================================

ALU_SWEEP_SEQUENCER -- requirements
Module: alu_sweep_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 2: cycles each opcode is held on the ALU before sampling; legal range 1..15.
REQ-002 Parameter NUM_OPS, default 16: opcodes swept, 0..NUM_OPS-1; legal range 1..16.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  single-cycle request to begin a sweep.
REQ-007 op_a_in  input  8  operand A, captured on an accepted start.
REQ-008 op_b_in  input  8  operand B, captured on an accepted start.
REQ-009 alu_a  output  8  operand A driven to the ALU.
REQ-010 alu_b  output  8  operand B driven to the ALU.
REQ-011 alu_sel  output  4  opcode driven to the ALU.
REQ-012 alu_result  input  8  ALU result; combinational function of alu_a, alu_b and alu_sel.
REQ-013 alu_e_bit  input  1  ALU extra/carry bit.
REQ-014 busy  output  1  high while a sweep is in progress.
REQ-015 done  output  1  one-cycle pulse when a sweep completes.
REQ-016 rd_addr  input  4  result-store read address.
REQ-017 rd_data  output  9  {e_bit, result} stored at rd_addr; registered.
REQ-018 checksum  output  16  running sum of the stored entries.

Function
REQ-019 FSM states: IDLE, DRIVE, FINISH.
- IDLE --start--> DRIVE.
- DRIVE --last sample--> FINISH.
- FINISH --> IDLE unconditionally after one cycle.
REQ-020 Start accepted only in IDLE; on the accepting edge:
- op_a_in/op_b_in latched into alu_a/alu_b;
- alu_sel=0, hold counter=0, checksum=0.
REQ-021 start in DRIVE or FINISH is ignored and has no side effects.
REQ-022 In DRIVE, each opcode is held for exactly HOLD_CYCLES cycles; the hold counter counts 0..HOLD_CYCLES-1.
REQ-023 On the edge where the counter equals HOLD_CYCLES-1:
- {alu_e_bit, alu_result} is written to store[alu_sel];
- checksum += zero-extended 9-bit entry, wrapping modulo 2^16.
REQ-024 After that sample:
- if alu_sel==NUM_OPS-1, go to FINISH;
- else alu_sel increments and the counter returns to 0.
REQ-025 alu_a and alu_b stay constant from the accepting edge until the next accepted start.
REQ-026 busy is high in DRIVE only. For a start accepted at edge k, busy is high for exactly NUM_OPS*HOLD_CYCLES cycles starting at k+1.
REQ-027 done is high only in FINISH, which occupies the single cycle immediately after busy falls.
REQ-028 rd_data = store[rd_addr] one cycle after rd_addr is presented.
REQ-029 A read and a write to the same address on the same edge return the old contents.
REQ-030 Reads are legal in every state.
REQ-031 Store entries not written by the current sweep keep their previous values.
REQ-032 checksum holds its final value until the next accepted start.

Reset
REQ-033 On rst, all of the following take effect at the next edge:
- state=IDLE, busy=0, done=0;
- alu_a=0, alu_b=0, alu_sel=0, hold counter=0;
- checksum=0, all 16 store entries=0, rd_data=0.
REQ-034 rst asserted mid-sweep aborts the sweep with no done pulse; partial store contents are cleared.
REQ-035 rst overrides a start presented on the same edge.

Structure
REQ-036 Shared package alu_seq_pkg holds:
- the FSM state enum;
- ENTRY_W=9 and CHK_W=16;
- HOLD_CYCLES and NUM_OPS defaults.
REQ-037 One sub-module, alu_result_store: 16x9 register file, one synchronous write port, one registered read port, synchronous reset clear.

Verification
REQ-038 The bench uses an ALU model with result=(a+b+sel) mod 256 and e_bit=carry out of that sum.
REQ-039 Basic sweep: a=15, b=3, HOLD=2, NUM_OPS=16, one start.
- busy is high 32 cycles, then done pulses once.
- store[i]={0, 18+i} for i=0..15.
- checksum=408.
REQ-040 Carry and wrap: a=200, b=50, HOLD=1.
- store[5]={0, 255}; store[6]={1, 0}.
- checksum = sum of all 16 entries, checked modulo 2^16.
REQ-041 Ignored start: start pulsed again at cycle 10 of a sweep.
- No restart; alu_a/alu_b unchanged; busy duration unchanged.
REQ-042 Reset mid-sweep: rst asserted at cycle 9 of a sweep.
- Next edge: busy=0, alu_sel=0, checksum=0.
- rd_data=0 for all 16 addresses; no done pulse.
REQ-043 Read/write collision: rd_addr=3 while store[3] is written.
- rd_data shows the old value that cycle and the new value on the next read.
REQ-044 Back-to-back sweeps: start held high continuously.
- Second sweep begins at the edge after done; checksum cleared then.
- Gap between the two busy periods is exactly 2 cycles.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU sweep sequencer and its result store.
package alu_seq_pkg;

  localparam int ENTRY_W         = 9;
  localparam int CHK_W           = 16;
  localparam int SEL_W           = 4;
  localparam int CNT_W           = 4;
  localparam int DEPTH           = 16;
  localparam int HOLD_CYCLES_DEF = 2;
  localparam int NUM_OPS_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/alu_result_store.sv
// 16x9 result register file: one synchronous write port, one registered read port.
module alu_result_store
  import alu_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [SEL_W-1:0]   waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [SEL_W-1:0]   raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] rdata_q;

  // NOTE: the whole array is cleared on reset, so it stays as flops, not a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make a same-edge read return the old entry.
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/alu_sweep_sequencer.sv
// Sweeps every opcode through an external ALU, holding each for HOLD_CYCLES,
// and records {e_bit, result} per opcode plus a running checksum.
module alu_sweep_sequencer
  import alu_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int NUM_OPS     = NUM_OPS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         op_a_in,
  input  logic [7:0]         op_b_in,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [SEL_W-1:0]   alu_sel,
  input  logic [7:0]         alu_result,
  input  logic               alu_e_bit,
  output logic               busy,
  output logic               done,
  input  logic [SEL_W-1:0]   rd_addr,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [CHK_W-1:0]   checksum
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_OPS - 1);

  state_e             state_q, state_d;
  logic [7:0]         a_q, a_d, b_q, b_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CHK_W-1:0]   chk_q, chk_d;
  logic               sample;
  logic [ENTRY_W-1:0] entry;

  assign entry = {alu_e_bit, alu_result};

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    sample  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRIVE;
          a_d     = op_a_in;
          b_d     = op_b_in;
          sel_d   = '0;
          cnt_d   = '0;
          chk_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == HOLD_LAST) begin
          // The ALU output has settled for the full hold window; capture it.
          sample = 1'b1;
          chk_d  = chk_q + CHK_W'(entry);
          if (sel_q == SEL_LAST) begin
            state_d = ST_FINISH;
          end else begin
            sel_d = sel_q + 1'b1;
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      chk_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
    end
  end

  alu_result_store u_store (
    .clk     (clk),
    .rst     (rst),
    .we_i    (sample),
    .waddr_i (sel_q),
    .wdata_i (entry),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_sel  = sel_q;
  assign busy     = (state_q == ST_DRIVE);
  assign done     = (state_q == ST_FINISH);
  assign checksum = chk_q;

endmodule

// File: tb/tb_alu_sweep_sequencer.sv
// Directed bench: two sequencers (HOLD=2 and HOLD=1) each driving an adder-style ALU model.
module tb_alu_sweep_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start2;
  logic [7:0] op_a, op_b;
  logic [3:0] rd_addr;

  logic [7:0]  alu_a1, alu_b1, res1, alu_a2, alu_b2, res2;
  logic [3:0]  alu_sel1, alu_sel2;
  logic        e1, e2, busy1, busy2, done1, done2;
  logic [8:0]  rd_data1, rd_data2, sum1, sum2;
  logic [15:0] checksum1, checksum2;

  int total = 0;
  int bad   = 0;
  logic [8:0] rec [64];

  always #5 clk = ~clk;

  assign sum1 = {1'b0, alu_a1} + {1'b0, alu_b1} + {5'b0, alu_sel1};
  assign res1 = sum1[7:0];
  assign e1   = sum1[8];
  assign sum2 = {1'b0, alu_a2} + {1'b0, alu_b2} + {5'b0, alu_sel2};
  assign res2 = sum2[7:0];
  assign e2   = sum2[8];

  alu_sweep_sequencer #(.HOLD_CYCLES(2), .NUM_OPS(16)) dut1 (
    .clk(clk), .rst(rst), .start(start), .op_a_in(op_a), .op_b_in(op_b),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1), .alu_result(res1),
    .alu_e_bit(e1), .busy(busy1), .done(done1), .rd_addr(rd_addr),
    .rd_data(rd_data1), .checksum(checksum1)
  );

  alu_sweep_sequencer #(.HOLD_CYCLES(1), .NUM_OPS(16)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op_a_in(op_a), .op_b_in(op_b),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_sel(alu_sel2), .alu_result(res2),
    .alu_e_bit(e2), .busy(busy2), .done(done2), .rd_addr(rd_addr),
    .rd_data(rd_data2), .checksum(checksum2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic read1(input logic [3:0] addr, input logic [8:0] exp, input string tag);
    rd_addr = addr;
    @(negedge clk);
    check(tag, rd_data1, exp);
  endtask

  // Runs one dut1 sweep whose start is already driven; optionally re-pulses start at inject_at.
  task automatic sweep1(input int inject_at, output int nb, output int nd);
    nb = 0;
    nd = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy1) begin
        rec[nb] = rd_data1;
        if (nb == inject_at) begin
          start = 1'b1;
          op_a  = 8'd99;
          op_b  = 8'd77;
        end
        nb++;
      end
      if (done1) nd++;
      if (nd > 0 && !done1 && !busy1) break;
    end
  endtask

  initial begin
    int nb, nd, gap, cyc, dseen;
    logic [15:0] gap_chk;

    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    op_a = '0; op_b = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_alu_a", alu_a1, 0);
    check("rst_sel", alu_sel1, 0);
    check("rst_chk", checksum1, 0);
    check("rst_rd", rd_data1, 0);
    check("rst_busy2", busy2, 0);
    rst = 1'b0;

    // Basic sweep: 15 + 3 + i
    op_a = 8'd15; op_b = 8'd3; start = 1'b1;
    sweep1(-1, nb, nd);
    check("basic_busy_len", nb, 32);
    check("basic_done_cnt", nd, 1);
    check("basic_chk", checksum1, 408);
    check("basic_alu_a", alu_a1, 15);
    for (int i = 0; i < 16; i++) read1(4'(i), 9'(18 + i), "basic_store");

    // Ignored start at cycle 10, plus read/write collision on address 3
    op_a = 8'd1; op_b = 8'd2; rd_addr = 4'd3; start = 1'b1;
    sweep1(10, nb, nd);
    check("ign_busy_len", nb, 32);
    check("ign_done_cnt", nd, 1);
    check("ign_alu_a", alu_a1, 1);
    check("ign_alu_b", alu_b1, 2);
    check("ign_no_restart", busy1, 0);
    check("ign_chk", checksum1, 168);
    check("coll_old", rec[8], 21);
    check("coll_new", rec[9], 6);

    // Reset at cycle 9 of a sweep
    op_a = 8'd15; op_b = 8'd3; start = 1'b1;
    cyc = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy1) begin
        if (cyc == 9) begin
          rst = 1'b1;
          break;
        end
        cyc++;
      end
    end
    check("mid_rst_reached", cyc, 9);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy1, 0);
    check("mid_rst_sel", alu_sel1, 0);
    check("mid_rst_chk", checksum1, 0);
    check("mid_rst_done", done1, 0);
    dseen = 0;
    for (int i = 0; i < 16; i++) begin
      read1(4'(i), 9'd0, "mid_rst_store");
      if (done1) dseen++;
    end
    check("mid_rst_no_done", dseen, 0);

    // Carry and wrap on the HOLD=1 instance: 200 + 50 + i
    op_a = 8'd200; op_b = 8'd50; start2 = 1'b1;
    nb = 0; nd = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (busy2) nb++;
      if (done2) nd++;
      if (nd > 0 && !done2 && !busy2) break;
    end
    check("carry_busy_len", nb, 16);
    check("carry_done_cnt", nd, 1);
    check("carry_chk", checksum2, 4120);
    rd_addr = 4'd5;  @(negedge clk); check("carry_store5", rd_data2, 9'h0FF);
    rd_addr = 4'd6;  @(negedge clk); check("carry_store6", rd_data2, 9'h100);
    rd_addr = 4'd15; @(negedge clk); check("carry_store15", rd_data2, 9'h109);

    // Back-to-back sweeps with start held high
    op_a = 8'd15; op_b = 8'd3; start = 1'b1;
    cyc = 0;
    while (!busy1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    nb = 0;
    while (busy1 && nb < 100) begin
      @(negedge clk);
      nb++;
    end
    gap_chk = checksum1;
    gap = 0; nd = 0;
    while (!busy1 && gap < 10) begin
      if (done1) nd++;
      @(negedge clk);
      gap++;
    end
    check("b2b_busy_len", nb, 32);
    check("b2b_gap_chk", gap_chk, 408);
    check("b2b_gap", gap, 2);
    check("b2b_done_cnt", nd, 1);
    check("b2b_chk_clear", checksum1, 0);
    start = 1'b0;
    cyc = 0;
    while ((busy1 || done1) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_second_chk", checksum1, 408);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
